// File: rtl/tt_sweep_pkg.sv
// Shared constants and state encoding for the truth-table sweep controller.
package tt_sweep_pkg;

    localparam int NUM_VECS = 16;
    localparam int VEC_W    = 4;
    localparam int TT_W     = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } sweep_state_t;

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable settle down-counter; zero flags the end of the settle window.
module tt_settle_timer #(
    parameter int TIMER_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               dec,
    input  logic [TIMER_W-1:0] load_val,
    output logic               zero
);

    logic [TIMER_W-1:0] count;

    // Load takes priority; decrement saturates at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Exhaustive 4-input gate sweep: drives vectors 0..15, waits a settle time,
// samples the gate output and compares the measured table with the expected one.
// Optional macro TT_SWEEP_FIRST_FAIL_EN adds first-mismatch index reporting.
//
// state  | meaning
// IDLE   | waiting for start_i
// SETTLE | vec_o held, settle timer running
// SAMPLE | gate output written into tt_captured_o[vec_o]
// DONE   | one-cycle done_o pulse, pass_o updated
module tt_sweep_ctrl
    import tt_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int TIMER_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [TT_W-1:0]  tt_expected_i,
    output logic [VEC_W-1:0] vec_o,
    input  logic             gate_out_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
`ifdef TT_SWEEP_FIRST_FAIL_EN
    output logic             first_fail_valid_o,
    output logic [VEC_W-1:0] first_fail_idx_o,
`endif
    output logic [TT_W-1:0]  tt_captured_o
);

    localparam logic [VEC_W-1:0]   LAST_VEC   = VEC_W'(NUM_VECS - 1);
    localparam logic [TIMER_W-1:0] SETTLE_RLD = TIMER_W'(SETTLE_CYCLES - 1);

    sweep_state_t    state;
    logic [TT_W-1:0] tt_exp_q;
    logic [TT_W-1:0] cap_next;
    logic            timer_load;
    logic            timer_dec;
    logic            timer_zero;

    // Timer reloads on start-accept and after every non-final sample.
    always_comb begin
        timer_load = 1'b0;
        timer_dec  = 1'b0;
        if (state == IDLE && start_i) begin
            timer_load = 1'b1;
        end else if (state == SAMPLE && !abort_i && vec_o != LAST_VEC) begin
            timer_load = 1'b1;
        end else if (state == SETTLE) begin
            timer_dec = 1'b1;
        end
    end

    // Captured table including the bit being sampled this cycle, so pass_o
    // can be decided on the same edge as the final sample.
    always_comb begin
        cap_next        = tt_captured_o;
        cap_next[vec_o] = gate_out_i;
    end

    tt_settle_timer #(
        .TIMER_W (TIMER_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .dec      (timer_dec),
        .load_val (SETTLE_RLD),
        .zero     (timer_zero)
    );

    // Sweep FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            vec_o              <= '0;
            busy_o             <= 1'b0;
            done_o             <= 1'b0;
            pass_o             <= 1'b0;
            tt_captured_o      <= '0;
            tt_exp_q           <= '0;
`ifdef TT_SWEEP_FIRST_FAIL_EN
            first_fail_valid_o <= 1'b0;
            first_fail_idx_o   <= '0;
`endif
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        tt_exp_q           <= tt_expected_i;
                        tt_captured_o      <= '0;
                        vec_o              <= '0;
                        busy_o             <= 1'b1;
                        state              <= SETTLE;
`ifdef TT_SWEEP_FIRST_FAIL_EN
                        first_fail_valid_o <= 1'b0;
                        first_fail_idx_o   <= '0;
`endif
                    end
                end
                SETTLE: begin
                    if (abort_i) begin
                        state  <= IDLE;
                        vec_o  <= '0;
                        busy_o <= 1'b0;
                    end else if (timer_zero) begin
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    if (abort_i) begin
                        state  <= IDLE;
                        vec_o  <= '0;
                        busy_o <= 1'b0;
                    end else begin
                        tt_captured_o <= cap_next;
`ifdef TT_SWEEP_FIRST_FAIL_EN
                        if (!first_fail_valid_o && (gate_out_i != tt_exp_q[vec_o])) begin
                            first_fail_valid_o <= 1'b1;
                            first_fail_idx_o   <= vec_o;
                        end
`endif
                        if (vec_o == LAST_VEC) begin
                            state  <= DONE;
                            done_o <= 1'b1;
                            busy_o <= 1'b0;
                            vec_o  <= '0;
                            pass_o <= (cap_next == tt_exp_q);
                        end else begin
                            vec_o <= vec_o + 1'b1;
                            state <= SETTLE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
